thumb_alu_issue: RTL and testbench

- Front end that drives the combinational datapath ALU: decodes 16-bit Thumb data-processing instructions into ALU opcode, operand selects and writeback controls.
- Owns the architectural NZCV register. Feeds it to the ALU `flag` input and captures the ALU's `flag_q` on issue.
- Sits between instruction fetch (valid/ready) and the register-file/ALU execute stage (valid/ready).

---
 rtl/thumb_alu_issue_if.sv | 32 +++
 rtl/thumb_alu_issue.sv | 224 ++++++++++++++++++++++
 tb/tb_thumb_alu_issue.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/thumb_alu_issue_if.sv
// Fetch-side and issue-side bus for the Thumb ALU issue stage.
interface thumb_alu_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        iss_valid;
  logic        iss_ready;
  logic [3:0]  iss_opcode;
  logic [2:0]  iss_ra;
  logic [2:0]  iss_rb;
  logic [2:0]  iss_rd;
  logic [31:0] iss_imm;
  logic        iss_imm_en;
  logic        iss_wr_en;
  logic        iss_set_flags;
  logic        iss_undef;
  logic [3:0]  alu_flag_q;

  // Decoder side
  modport slave (
    input  instr_valid, instr, iss_ready, alu_flag_q,
    output instr_ready, iss_valid, iss_opcode, iss_ra, iss_rb, iss_rd,
           iss_imm, iss_imm_en, iss_wr_en, iss_set_flags, iss_undef
  );

  // Fetch / execute side
  modport master (
    output instr_valid, instr, iss_ready, alu_flag_q,
    input  instr_ready, iss_valid, iss_opcode, iss_ra, iss_rb, iss_rd,
           iss_imm, iss_imm_en, iss_wr_en, iss_set_flags, iss_undef
  );
endinterface

// File: rtl/thumb_alu_issue.sv
// Thumb data-processing decode and issue front end; owns the NZCV register.
// Optional THUMB_ALU_ISSUE_SKID_EN adds a 2-entry skid buffer ahead of the
// issue slot so instr_ready no longer depends combinationally on iss_ready.
module thumb_alu_issue #(
  parameter int unsigned CNT_W    = 8,
  parameter logic [3:0]  FLAG_RST = 4'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  thumb_alu_issue_if.slave bus,
  output logic [3:0]       apsr_flag,
  output logic [CNT_W-1:0] undef_cnt
);

  localparam int unsigned OPC_W = 4;
  localparam int unsigned REG_W = 3;
  localparam int unsigned IMM_W = 32;

  localparam logic [OPC_W-1:0] OPC_ADD   = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ADC   = 4'h1;
  localparam logic [OPC_W-1:0] OPC_SUB   = 4'h2;
  localparam logic [OPC_W-1:0] OPC_RSB   = 4'h3;
  localparam logic [OPC_W-1:0] OPC_SBC   = 4'h4;
  localparam logic [OPC_W-1:0] OPC_AND   = 4'h5;
  localparam logic [OPC_W-1:0] OPC_ORR   = 4'h6;
  localparam logic [OPC_W-1:0] OPC_EOR   = 4'h7;
  localparam logic [OPC_W-1:0] OPC_MOV   = 4'h8;
  localparam logic [OPC_W-1:0] OPC_UNDEF = 4'hB;
  localparam logic [OPC_W-1:0] OPC_MVN   = 4'hC;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic             imm_en;
    logic             wr_en;
    logic             set_flags;
    logic             undef;
  } iss_t;

  // Map one 16-bit Thumb word onto ALU controls; anything unsupported is undef.
  function automatic iss_t decode(input logic [15:0] ins);
    iss_t d;
    d        = '0;
    d.opcode = OPC_UNDEF;
    d.undef  = 1'b1;
    if (ins[15:11] == 5'b00011) begin
      d           = '0;
      d.opcode    = ins[9] ? OPC_SUB : OPC_ADD;
      d.ra        = ins[5:3];
      d.rd        = ins[2:0];
      d.wr_en     = 1'b1;
      d.set_flags = 1'b1;
      if (ins[10]) begin
        d.imm    = IMM_W'(ins[8:6]);
        d.imm_en = 1'b1;
      end else begin
        d.rb = ins[8:6];
      end
    end else if (ins[15:13] == 3'b001) begin
      d           = '0;
      d.ra        = ins[10:8];
      d.rd        = ins[10:8];
      d.imm       = IMM_W'(ins[7:0]);
      d.imm_en    = 1'b1;
      d.set_flags = 1'b1;
      d.wr_en     = (ins[12:11] != 2'd1);
      case (ins[12:11])
        2'd0:    d.opcode = OPC_MOV;
        2'd2:    d.opcode = OPC_ADD;
        default: d.opcode = OPC_SUB;
      endcase
    end else if (ins[15:10] == 6'b010000) begin
      d           = '0;
      d.ra        = ins[2:0];
      d.rb        = ins[5:3];
      d.rd        = ins[2:0];
      d.wr_en     = 1'b1;
      d.set_flags = 1'b1;
      case (ins[9:6])
        4'h0: d.opcode = OPC_AND;
        4'h1: d.opcode = OPC_EOR;
        4'h5: d.opcode = OPC_ADC;
        4'h6: d.opcode = OPC_SBC;
        4'hC: d.opcode = OPC_ORR;
        4'h8: begin d.opcode = OPC_AND; d.wr_en = 1'b0; end
        4'hA: begin d.opcode = OPC_SUB; d.wr_en = 1'b0; end
        4'hB: begin d.opcode = OPC_ADD; d.wr_en = 1'b0; end
        // NEG: ALU reverse-subtracts Rs from a zero immediate
        4'h9: begin d.opcode = OPC_RSB; d.ra = ins[5:3]; d.imm_en = 1'b1; end
        4'hF: begin d.opcode = OPC_MVN; d.ra = ins[5:3]; end
        default: begin
          d        = '0;
          d.opcode = OPC_UNDEF;
          d.undef  = 1'b1;
        end
      endcase
    end
    return d;
  endfunction

  iss_t             slot_q, slot_d;
  logic             valid_q, valid_d;
  logic [3:0]       apsr_q, apsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  iss_t             dec_c;
  logic             issue_c;
  logic             accept_c;

  assign dec_c    = decode(bus.instr);
  assign issue_c  = valid_q && bus.iss_ready && !flush;
  assign accept_c = bus.instr_valid && bus.instr_ready;

`ifdef THUMB_ALU_ISSUE_SKID_EN
  localparam int unsigned      FILL_W    = 2;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(2);

  iss_t [1:0]        fifo_q, fifo_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              ready_q, ready_d;
  logic              slot_free_c;

  assign slot_free_c     = !valid_q || issue_c;
  assign bus.instr_ready = ready_q && !flush;
`else
  assign bus.instr_ready = !flush && (!valid_q || bus.iss_ready);
`endif

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
      apsr_q  <= FLAG_RST;
      cnt_q   <= '0;
`ifdef THUMB_ALU_ISSUE_SKID_EN
      fifo_q  <= '0;
      fill_q  <= '0;
      ready_q <= 1'b1;
`endif
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
      apsr_q  <= apsr_d;
      cnt_q   <= cnt_d;
`ifdef THUMB_ALU_ISSUE_SKID_EN
      fifo_q  <= fifo_d;
      fill_q  <= fill_d;
      ready_q <= ready_d;
`endif
    end
  end

  // Next state: flag/counter update on issue, slot fill/drain, flush priority
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    apsr_d  = apsr_q;
    cnt_d   = cnt_q;
`ifdef THUMB_ALU_ISSUE_SKID_EN
    fifo_d  = fifo_q;
    fill_d  = fill_q;
    ready_d = ready_q;
`endif
    if (issue_c && slot_q.set_flags) apsr_d = bus.alu_flag_q;
    if (issue_c && slot_q.undef && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
`ifdef THUMB_ALU_ISSUE_SKID_EN
    if (flush) begin
      valid_d = 1'b0;
      fill_d  = '0;
    end else begin
      if (issue_c) valid_d = 1'b0;
      if (slot_free_c && (fill_q != '0)) begin
        slot_d    = fifo_q[0];
        valid_d   = 1'b1;
        fifo_d[0] = fifo_q[1];
        fill_d    = fill_q - FILL_W'(1);
      end
      if (accept_c) begin
        // Empty buffer and free slot: bypass straight to the slot
        if (slot_free_c && (fill_q == '0)) begin
          slot_d  = dec_c;
          valid_d = 1'b1;
        end else if (fill_d == '0) begin
          fifo_d[0] = dec_c;
          fill_d    = FILL_W'(1);
        end else begin
          fifo_d[1] = dec_c;
          fill_d    = FILL_FULL;
        end
      end
    end
    ready_d = (fill_d != FILL_FULL);
`else
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_c) begin
      slot_d  = dec_c;
      valid_d = 1'b1;
    end else if (issue_c) begin
      valid_d = 1'b0;
    end
`endif
  end

  assign bus.iss_valid     = valid_q;
  assign bus.iss_opcode    = slot_q.opcode;
  assign bus.iss_ra        = slot_q.ra;
  assign bus.iss_rb        = slot_q.rb;
  assign bus.iss_rd        = slot_q.rd;
  assign bus.iss_imm       = slot_q.imm;
  assign bus.iss_imm_en    = slot_q.imm_en;
  assign bus.iss_wr_en     = slot_q.wr_en;
  assign bus.iss_set_flags = slot_q.set_flags;
  assign bus.iss_undef     = slot_q.undef;
  assign apsr_flag         = apsr_q;
  assign undef_cnt         = cnt_q;

endmodule

// File: tb/tb_thumb_alu_issue.sv
// Self-checking bench for thumb_alu_issue (base build, CNT_W=2).
module tb_thumb_alu_issue;

  localparam int CNT_W   = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  // Per-op lookup tables, nibble/bit index = op field
  localparam logic [15:0] F3_OPC    = 16'h2028;
  localparam logic [3:0]  F3_WR     = 4'hD;
  localparam logic [63:0] F4_OPC    = 64'hCBB6_0235_B41B_BB75;
  localparam logic [15:0] F4_WR     = 16'h9263;
  localparam logic [15:0] F4_UNDEF  = 16'h609C;
  localparam logic [15:0] F4_RA_RS  = 16'h8200;

  typedef struct packed {
    logic [3:0]  opc;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rd;
    logic [31:0] imm;
    logic        imm_en;
    logic        wr;
    logic        sf;
    logic        undef;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [3:0] apsr_flag;
  logic [CNT_W-1:0] undef_cnt;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  thumb_alu_issue_if bus();

  thumb_alu_issue #(.CNT_W(CNT_W), .FLAG_RST(4'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .apsr_flag (apsr_flag),
    .undef_cnt (undef_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode, table-driven from the instruction set description
  function automatic exp_t m_decode(input logic [15:0] w);
    exp_t e;
    int op;
    e = '0;
    e.opc = 4'hB;
    e.undef = 1'b1;
    if (w[15:11] == 5'b00011) begin
      e = '0;
      e.opc = w[9] ? 4'd2 : 4'd0;
      e.ra = w[5:3]; e.rd = w[2:0]; e.wr = 1'b1; e.sf = 1'b1;
      if (w[10]) begin e.imm = {29'd0, w[8:6]}; e.imm_en = 1'b1; end
      else e.rb = w[8:6];
    end else if (w[15:13] == 3'b001) begin
      op = int'(w[12:11]);
      e = '0;
      e.opc = F3_OPC[op*4 +: 4];
      e.ra = w[10:8]; e.rd = w[10:8];
      e.imm = {24'd0, w[7:0]}; e.imm_en = 1'b1; e.sf = 1'b1;
      e.wr = F3_WR[op];
    end else if (w[15:10] == 6'b010000 && !F4_UNDEF[w[9:6]]) begin
      op = int'(w[9:6]);
      e = '0;
      e.opc = F4_OPC[op*4 +: 4];
      e.ra = F4_RA_RS[op] ? w[5:3] : w[2:0];
      e.rb = w[5:3]; e.rd = w[2:0];
      e.wr = F4_WR[op]; e.sf = 1'b1;
      e.imm_en = (op == 9);
    end
    return e;
  endfunction

  // Behavioural model of the slot, NZCV and undef counter
  bit   m_valid;
  exp_t m_slot;
  logic [3:0] m_apsr;
  int   m_cnt;

  always @(posedge clk or negedge rst_n) begin
    bit iss, acc;
    if (!rst_n) begin
      m_valid = 1'b0; m_slot = '0; m_apsr = 4'h0; m_cnt = 0;
    end else begin
      iss = m_valid && bus.iss_ready && !flush;
      acc = bus.instr_valid && !flush && (!m_valid || bus.iss_ready);
      if (iss && m_slot.sf) m_apsr = bus.alu_flag_q;
      if (iss && m_slot.undef && m_cnt < CNT_SAT) m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (acc) begin m_slot = m_decode(bus.instr); m_valid = 1'b1; end
      else if (iss) m_valid = 1'b0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n && run) begin
      chk("instr_ready", 64'(bus.instr_ready),
          64'(!flush && (!m_valid || bus.iss_ready)));
      chk("iss_valid", 64'(bus.iss_valid), 64'(m_valid));
      chk("apsr_flag", 64'(apsr_flag), 64'(m_apsr));
      chk("undef_cnt", 64'(undef_cnt), 64'(m_cnt));
      if (m_valid)
        chk("iss_fields",
            64'({bus.iss_opcode, bus.iss_ra, bus.iss_rb, bus.iss_rd, bus.iss_imm,
                 bus.iss_imm_en, bus.iss_wr_en, bus.iss_set_flags, bus.iss_undef}),
            64'(m_slot));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] extra [7] = '{16'h4008, 16'h43C8, 16'h4288, 16'h1E48,
                             16'h3A10, 16'hB000, 16'h4390};
  logic [3:0]  extra_f [7] = '{4'h4, 4'h8, 4'h2, 4'h1, 4'h3, 4'hF, 4'h6};

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = 16'h0; bus.iss_ready = 1'b0; bus.alu_flag_q = 4'h0;
    repeat (2) tick();
    chk("rst_valid", 64'(bus.iss_valid), 64'd0);
    chk("rst_apsr", 64'(apsr_flag), 64'd0);
    chk("rst_cnt", 64'(undef_cnt), 64'd0);
    chk("rst_opcode", 64'(bus.iss_opcode), 64'd0);
    rst_n = 1'b1;
    run = 1'b1;
    tick();

    // MOV R0,#5
    bus.instr = 16'h2005; bus.instr_valid = 1'b1; bus.iss_ready = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    chk("mov_opcode", 64'(bus.iss_opcode), 64'd8);
    chk("mov_rd", 64'(bus.iss_rd), 64'd0);
    chk("mov_imm", 64'(bus.iss_imm), 64'd5);
    chk("mov_ctl", 64'({bus.iss_imm_en, bus.iss_wr_en, bus.iss_set_flags}), 64'b111);
    tick();

    // CMP R1,#0 with flags 0110 at issue
    bus.instr = 16'h2900; bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0; bus.alu_flag_q = 4'b0110;
    chk("cmp_opcode", 64'(bus.iss_opcode), 64'd2);
    chk("cmp_wr", 64'(bus.iss_wr_en), 64'd0);
    tick();
    chk("cmp_apsr", 64'(apsr_flag), 64'h6);

    // ADC R2,R3 then NEG R0,R1 back to back
    bus.instr = 16'h415A; bus.instr_valid = 1'b1; bus.alu_flag_q = 4'b0010;
    tick();
    chk("adc_fields", 64'({bus.iss_opcode, bus.iss_ra, bus.iss_rb, bus.iss_rd, bus.iss_imm_en}),
        64'({4'd1, 3'd2, 3'd3, 3'd2, 1'b0}));
    bus.instr = 16'h4248;
    tick();
    chk("neg_fields", 64'({bus.iss_opcode, bus.iss_ra, bus.iss_imm, bus.iss_imm_en}),
        64'({4'd3, 3'd1, 32'd0, 1'b1}));
    chk("adc_apsr", 64'(apsr_flag), 64'h2);
    bus.instr_valid = 1'b0; bus.alu_flag_q = 4'b1000;
    tick();
    chk("neg_apsr", 64'(apsr_flag), 64'h8);

    // LSL R0,R1 five times: undefined, counter saturates at 3
    bus.instr = 16'h4088; bus.instr_valid = 1'b1; bus.alu_flag_q = 4'hF;
    repeat (5) tick();
    chk("lsl_ctl", 64'({bus.iss_undef, bus.iss_opcode, bus.iss_wr_en, bus.iss_set_flags}),
        64'({1'b1, 4'hB, 1'b0, 1'b0}));
    bus.instr_valid = 1'b0;
    tick();
    chk("lsl_cnt_sat", 64'(undef_cnt), 64'd3);
    chk("lsl_apsr", 64'(apsr_flag), 64'h8);

    // Stall with ADDS R2,R1,#2 held for 3 cycles, then flush
    bus.instr = 16'h1C8A; bus.instr_valid = 1'b1; bus.iss_ready = 1'b0;
    tick();
    bus.instr = 16'h1A8B;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", 64'(bus.instr_ready), 64'd0);
      chk("stall_fields", 64'({bus.iss_valid, bus.iss_opcode, bus.iss_ra, bus.iss_rd, bus.iss_imm}),
          64'({1'b1, 4'd0, 3'd1, 3'd2, 32'd2}));
    end
    flush = 1'b1; bus.iss_ready = 1'b1; bus.alu_flag_q = 4'b1001;
    #1;
    chk("flush_ready", 64'(bus.instr_ready), 64'd0);
    tick();
    flush = 1'b0; bus.instr_valid = 1'b0;
    chk("flush_valid", 64'(bus.iss_valid), 64'd0);
    chk("flush_apsr", 64'(apsr_flag), 64'h8);
    tick();

    // Assorted encodings, model-checked every cycle
    for (int i = 0; i < 7; i++) begin
      bus.instr = extra[i]; bus.instr_valid = 1'b1; bus.alu_flag_q = extra_f[i];
      tick();
    end
    bus.instr_valid = 1'b0;
    repeat (2) tick();

    // Async reset mid-transfer
    bus.instr = 16'h2005; bus.instr_valid = 1'b1; bus.iss_ready = 1'b0;
    tick();
    bus.instr_valid = 1'b0;
    chk("pre_rst_valid", 64'(bus.iss_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.iss_valid), 64'd0);
    chk("async_rst_apsr", 64'(apsr_flag), 64'd0);
    chk("async_rst_cnt", 64'(undef_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
